fpmul_stage3_round: RTL and testbench

FPMUL_STAGE3_ROUND -- requirements
Module: fpmul_stage3_round

---
 rtl/fpmul_pkg.sv | 31 +++
 rtl/fpmul_stage3_round_if.sv | 45 ++++
 rtl/fpmul_round_rne.sv | 44 ++++
 rtl/fpmul_stage3_round.sv | 109 ++++++++++
 tb/tb_fpmul_stage3_round.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpmul_pkg.sv
// Shared types and constants for the floating-point multiplier pipeline.
// Stage-3 rounding mode is selected by FPMUL_STAGE3_RNE_EN (see fpmul_round_rne).
package fpmul_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned SIG_W = 28;

    // Low-order significand bit positions: lsb of the kept result, then guard/round/sticky.
    localparam int unsigned L_BIT = 3;
    localparam int unsigned G_BIT = 2;
    localparam int unsigned R_BIT = 1;
    localparam int unsigned S_BIT = 0;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             exp_pos;
        logic             exp_neg;
        logic             is_inf;
        logic             is_nan;
        logic             is_zero;
    } beat_t;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } skid_state_e;

endpackage

// File: rtl/fpmul_stage3_round_if.sv
// Stage2 -> stage3 -> stage4 handshake bundle. The slave modport is the rounding stage,
// the master modport is its environment (upstream producer plus downstream consumer).
interface fpmul_stage3_round_if #(
    parameter int unsigned SIG_WIDTH = fpmul_pkg::SIG_W
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic                 SIGN;
    logic                 EXP_pos;
    logic                 EXP_neg;
    logic                 isINF_tab;
    logic                 isNaN;
    logic                 isZ_tab;
    logic [7:0]           EXP_in;
    logic [SIG_WIDTH-1:0] SIG_in;

    logic [7:0]           EXP_out_round;
    logic [SIG_WIDTH-1:0] SIG_out_round;
    logic                 SIGN_out;
    logic                 EXP_pos_out;
    logic                 EXP_neg_out;
    logic                 isINF_tab_out;
    logic                 isNaN_out;
    logic                 isZ_tab_out;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  in_valid, SIGN, EXP_pos, EXP_neg, isINF_tab, isNaN, isZ_tab, EXP_in, SIG_in,
        input  out_ready,
        output in_ready,
        output EXP_out_round, SIG_out_round, SIGN_out, EXP_pos_out, EXP_neg_out,
        output isINF_tab_out, isNaN_out, isZ_tab_out, out_valid
    );

    modport master (
        output in_valid, SIGN, EXP_pos, EXP_neg, isINF_tab, isNaN, isZ_tab, EXP_in, SIG_in,
        output out_ready,
        input  in_ready,
        input  EXP_out_round, SIG_out_round, SIGN_out, EXP_pos_out, EXP_neg_out,
        input  isINF_tab_out, isNaN_out, isZ_tab_out, out_valid
    );

endinterface

// File: rtl/fpmul_round_rne.sv
// Combinational pre-normalize and round of the unrounded product significand.
// FPMUL_STAGE3_RNE_EN defined: round-to-nearest-even at bit 3; undefined: truncate.
module fpmul_round_rne import fpmul_pkg::*; #(
    parameter int unsigned SIG_WIDTH = SIG_W
) (
    input  logic [SIG_WIDTH-1:0] sig_in,
    input  logic [EXP_W-1:0]     exp_in,
    input  logic                 exp_pos_in,
    output logic [SIG_WIDTH-1:0] sig_out,
    output logic [EXP_W-1:0]     exp_out,
    output logic                 exp_pos_out
);

    logic [SIG_WIDTH-1:0] sig_norm;
    logic [SIG_WIDTH-1:0] sig_sum;
    logic                 round_up;

    always_comb begin
        sig_norm    = sig_in;
        exp_out     = exp_in;
        exp_pos_out = exp_pos_in;
        if (sig_in[SIG_WIDTH-1]) begin
            sig_norm         = {1'b0, sig_in[SIG_WIDTH-1:1]};
            sig_norm[S_BIT]  = sig_in[1] | sig_in[0];
            exp_out          = exp_in + EXP_W'(1);
            // Exponent wrap from FF to 00 is an overflow the later stages must see.
            if (exp_in == '1) begin
                exp_pos_out = 1'b1;
            end
        end

`ifdef FPMUL_STAGE3_RNE_EN
        round_up = sig_norm[G_BIT] & (sig_norm[R_BIT] | sig_norm[S_BIT] | sig_norm[L_BIT]);
`else
        round_up = 1'b0;
`endif

        // A carry into the top bit is left for the renormalizing stage downstream.
        sig_sum        = sig_norm + {{(SIG_WIDTH-4){1'b0}}, round_up, 3'b000};
        sig_out        = sig_sum;
        sig_out[2:0]   = 3'b000;
    end

endmodule

// File: rtl/fpmul_stage3_round.sv
// Multiplier stage 3: rounding (fpmul_round_rne) registered into a 2-entry skid buffer.
// Rounding mode follows FPMUL_STAGE3_RNE_EN; in_ready is a pure register output.
module fpmul_stage3_round import fpmul_pkg::*; #(
    parameter int unsigned SIG_WIDTH = SIG_W
) (
    input logic                 clk,
    input logic                 rst_n,
    fpmul_stage3_round_if.slave bus
);

    if (SIG_WIDTH != SIG_W) begin : g_width_check
        $error("SIG_WIDTH must equal fpmul_pkg::SIG_W");
    end

    logic [SIG_WIDTH-1:0] sig_rnd;
    logic [EXP_W-1:0]     exp_rnd;
    logic                 exp_pos_rnd;
    beat_t                beat_in;
    beat_t                out_q;
    beat_t                skid_q;
    skid_state_e          state_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 accept;
    logic                 emit;

    fpmul_round_rne #(
        .SIG_WIDTH (SIG_WIDTH)
    ) u_round (
        .sig_in      (bus.SIG_in),
        .exp_in      (bus.EXP_in),
        .exp_pos_in  (bus.EXP_pos),
        .sig_out     (sig_rnd),
        .exp_out     (exp_rnd),
        .exp_pos_out (exp_pos_rnd)
    );

    always_comb begin
        beat_in         = '0;
        beat_in.sign    = bus.SIGN;
        beat_in.exp     = exp_rnd;
        beat_in.sig     = sig_rnd;
        beat_in.exp_pos = exp_pos_rnd;
        beat_in.exp_neg = bus.EXP_neg;
        beat_in.is_inf  = bus.isINF_tab;
        beat_in.is_nan  = bus.isNaN;
        beat_in.is_zero = bus.isZ_tab;
    end

    assign accept = bus.in_valid & in_ready_q;
    assign emit   = out_valid_q & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        out_q       <= beat_in;
                        out_valid_q <= 1'b1;
                        state_q     <= StOne;
                    end
                end
                StOne: begin
                    if (accept && emit) begin
                        out_q <= beat_in;
                    end else if (accept) begin
                        skid_q     <= beat_in;
                        in_ready_q <= 1'b0;
                        state_q    <= StFull;
                    end else if (emit) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StEmpty;
                    end
                end
                StFull: begin
                    // in_ready is low here, so only the drain side can move.
                    if (emit) begin
                        out_q      <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= StOne;
                    end
                end
                default: begin
                    state_q     <= StEmpty;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.SIG_out_round = out_q.sig;
    assign bus.EXP_out_round = out_q.exp;
    assign bus.SIGN_out      = out_q.sign;
    assign bus.EXP_pos_out   = out_q.exp_pos;
    assign bus.EXP_neg_out   = out_q.exp_neg;
    assign bus.isINF_tab_out = out_q.is_inf;
    assign bus.isNaN_out     = out_q.is_nan;
    assign bus.isZ_tab_out   = out_q.is_zero;

endmodule

// File: tb/tb_fpmul_stage3_round.sv
// Scoreboard bench for fpmul_stage3_round: directed rounding cases, skid backpressure,
// reset while full, and a random-handshake run; expects FPMUL_STAGE3_RNE_EN as built.
module tb_fpmul_stage3_round;
    import fpmul_pkg::*;

    localparam int unsigned SW = 28;

    // flags order: {sign, exp_pos, exp_neg, is_inf, is_nan, is_zero}
    typedef struct packed {
        logic [SW-1:0] sig;
        logic [7:0]    exp;
        logic [5:0]    flags;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpmul_stage3_round_if #(.SIG_WIDTH(SW)) bus ();

    fpmul_stage3_round #(
        .SIG_WIDTH (SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    logic rand_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    // Reference: independent arithmetic formulation of pre-normalize + round.
    function automatic exp_t ref_model(input logic [SW-1:0] sig, input logic [7:0] e,
                                       input logic [5:0] f);
        exp_t r;
        longint unsigned v;
        longint unsigned rem;
        v = longint'(sig);
        r.exp = e;
        r.flags = f;
        if (sig[SW-1]) begin
            v = (v >> 1) | (v & 1);
            r.exp = e + 8'd1;
            if (e == 8'hFF) r.flags[4] = 1'b1;
        end
        rem = v % 8;
        v = v - rem;
`ifdef FPMUL_STAGE3_RNE_EN
        if (rem > 4 || (rem == 4 && ((v >> 3) & 1) == 1)) v = v + 8;
`endif
        r.sig = SW'(v);
        return r;
    endfunction

    task automatic drive(input logic [SW-1:0] sig, input logic [7:0] e, input logic [5:0] f);
        bus.in_valid  = 1'b1;
        bus.SIG_in    = sig;
        bus.EXP_in    = e;
        {bus.SIGN, bus.EXP_pos, bus.EXP_neg, bus.isINF_tab, bus.isNaN, bus.isZ_tab} = f;
    endtask

    // Holds the beat until accepted; the expected result is queued at acceptance.
    task automatic send(input logic [SW-1:0] sig, input logic [7:0] e, input logic [5:0] f,
                        input exp_t want);
        int  waited = 0;
        bit  done = 0;
        drive(sig, e, f);
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(want);
                done = 1;
            end else if (waited > 200) begin
                check("accept_timeout", 64'(bus.in_ready), 64'd1);
                done = 1;
            end
            waited++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        bus.in_valid = 1'b0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                mon_e = sb.pop_front();
                check("sig", 64'(bus.SIG_out_round), 64'(mon_e.sig));
                check("exp", 64'(bus.EXP_out_round), 64'(mon_e.exp));
                check("flags", 64'({bus.SIGN_out, bus.EXP_pos_out, bus.EXP_neg_out,
                                    bus.isINF_tab_out, bus.isNaN_out, bus.isZ_tab_out}),
                      64'(mon_e.flags));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SW-1:0] r_sig;
        logic [7:0]    r_exp;
        logic [5:0]    r_flg;
        exp_t          b1;
        exp_t          b2;
        exp_t          b3;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive('0, '0, '0);
        bus.in_valid  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sig", 64'(bus.SIG_out_round), 64'd0);
        check("rst_exp", 64'(bus.EXP_out_round), 64'd0);
        check("rst_flags", 64'({bus.SIGN_out, bus.EXP_pos_out, bus.EXP_neg_out,
                                bus.isINF_tab_out, bus.isNaN_out, bus.isZ_tab_out}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", 64'(bus.in_ready), 64'd1);
        check("rel_out_valid", 64'(bus.out_valid), 64'd0);

        // Directed rounding cases with the consumer always ready.
        bus.out_ready = 1'b1;
`ifdef FPMUL_STAGE3_RNE_EN
        send(28'h400000C, 8'h80, 6'b0, '{sig: 28'h4000010, exp: 8'h80, flags: 6'b0});
        check("lat_valid", 64'(bus.out_valid), 64'd1);
        check("lat_sig", 64'(bus.SIG_out_round), 64'h4000010);
        send(28'h7FFFFFC, 8'h7F, 6'b0, '{sig: 28'h8000000, exp: 8'h7F, flags: 6'b0});
`else
        send(28'h400000C, 8'h80, 6'b0, '{sig: 28'h4000008, exp: 8'h80, flags: 6'b0});
        check("lat_valid", 64'(bus.out_valid), 64'd1);
        check("lat_sig", 64'(bus.SIG_out_round), 64'h4000008);
        send(28'h7FFFFFC, 8'h7F, 6'b0, '{sig: 28'h7FFFFF8, exp: 8'h7F, flags: 6'b0});
`endif
        send(28'h4000004, 8'h80, 6'b0, '{sig: 28'h4000000, exp: 8'h80, flags: 6'b0});
        send(28'h8000000, 8'hFF, 6'b0, '{sig: 28'h4000000, exp: 8'h00, flags: 6'b010000});
        send(28'h8000003, 8'h10, 6'b101001, '{sig: 28'h4000000, exp: 8'h11, flags: 6'b101001});
        drain();

        // Back-to-back beats against a stalled consumer.
        bus.out_ready = 1'b0;
        b1 = ref_model(28'h1234567, 8'h01, 6'b100000);
        b2 = ref_model(28'h2345678, 8'h02, 6'b000100);
        b3 = ref_model(28'h9ABCDEF, 8'h03, 6'b000001);
        send(28'h1234567, 8'h01, 6'b100000, b1);
        send(28'h2345678, 8'h02, 6'b000100, b2);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_out_valid", 64'(bus.out_valid), 64'd1);
        drive(28'h9ABCDEF, 8'h03, 6'b000001);
        @(posedge clk);
        #1;
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_sig", 64'(bus.SIG_out_round), 64'(b1.sig));
        bus.out_ready = 1'b1;
        send(28'h9ABCDEF, 8'h03, 6'b000001, b3);
        drain();

        // Reset while FULL discards both buffered beats.
        bus.out_ready = 1'b0;
        send(28'h0000011, 8'h20, 6'b0, ref_model(28'h0000011, 8'h20, 6'b0));
        send(28'h0000022, 8'h21, 6'b0, ref_model(28'h0000022, 8'h21, 6'b0));
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_sig", 64'(bus.SIG_out_round), 64'd0);
        sb.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        send(28'h0123458, 8'h10, 6'b000010, '{sig: 28'h0123458, exp: 8'h10, flags: 6'b000010});
        drain();

        // Random handshake run against the reference model.
        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            r_sig = SW'($urandom);
            r_exp = 8'($urandom);
            r_flg = 6'($urandom);
            send(r_sig, r_exp, r_flg, ref_model(r_sig, r_exp, r_flg));
        end
        bus.in_valid = 1'b0;
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
